// File: rtl/interpo_lerp.sv
// Linear interpolator over a 64-entry signed coefficient RAM: reads entries i and
// i+1, then returns a + floor((b - a) * f / 1024) through a valid/ready handshake.
module interpo_lerp #(
  parameter int WRAP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  output logic [5:0]  mem_address,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CALC,
    OUT
  } state_t;

  state_t      state_q;
  logic [5:0]  i_q;
  logic [9:0]  f_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] y_q;

  logic [5:0]         next_idx;
  logic signed [32:0] diff;
  logic signed [43:0] prod;
  logic signed [31:0] delta;
  logic [31:0]        y_d;

  // Top entry either wraps to entry 0 or clamps onto itself.
  always_comb begin
    if (WRAP != 0) next_idx = i_q + 6'd1;
    else           next_idx = (i_q == 6'd63) ? i_q : i_q + 6'd1;
  end

  // The arithmetic shift floors toward minus infinity, so f=0 yields exactly a.
  always_comb begin
    diff  = $signed({b_q[31], b_q}) - $signed({a_q[31], a_q});
    prod  = diff * $signed({1'b0, f_q});
    delta = 32'(prod >>> 10);
    y_d   = a_q + delta;
  end

  always_comb begin
    case (state_q)
      IDLE:    mem_address = in_x[15:10];
      RD_A:    mem_address = next_idx;
      default: mem_address = i_q;
    endcase
  end

  assign mem_clken = 1'b1;
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == OUT);
  assign out_y     = y_q;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      f_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            i_q     <= in_x[15:10];
            f_q     <= in_x[9:0];
            state_q <= RD_A;
          end
        end
        RD_A: begin
          a_q     <= mem_readdata;
          state_q <= RD_B;
        end
        RD_B: begin
          b_q     <= mem_readdata;
          state_q <= CALC;
        end
        CALC: begin
          y_q     <= y_d;
          state_q <= OUT;
        end
        OUT: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interpo_lerp.sv
// Directed bench for interpo_lerp: one wrapping and one clamping instance share
// stimulus, each reading its own registered-read model of the coefficient RAM.
module tb_interpo_lerp;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_x;
  logic        out_ready;

  logic        rdy_w, clken_w, ov_w, busy_w;
  logic [5:0]  addr_w;
  logic [31:0] rd_w, y_w;
  logic        rdy_c, clken_c, ov_c, busy_c;
  logic [5:0]  addr_c;
  logic [31:0] rd_c, y_c;

  logic [31:0] ram [64];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  interpo_lerp #(.WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_w), .in_x(in_x),
    .mem_address(addr_w), .mem_clken(clken_w), .mem_readdata(rd_w),
    .out_valid(ov_w), .out_ready(out_ready), .out_y(y_w), .busy(busy_w)
  );

  interpo_lerp #(.WRAP(0)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_c), .in_x(in_x),
    .mem_address(addr_c), .mem_clken(clken_c), .mem_readdata(rd_c),
    .out_valid(ov_c), .out_ready(out_ready), .out_y(y_c), .busy(busy_c)
  );

  always @(posedge clk) begin
    rd_w <= ram[addr_w];
    rd_c <= ram[addr_c];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Accept one request with out_ready=1 and follow it through to IDLE again.
  task automatic run_txn(input string tag, input logic [15:0] x,
                         input logic [31:0] exp_w, input logic [31:0] exp_c);
    logic [5:0] idx, nxt_w, nxt_c;
    idx   = x[15:10];
    nxt_w = idx + 6'd1;
    nxt_c = (idx == 6'd63) ? idx : idx + 6'd1;
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = x;
    #1;
    check({tag, " in_ready"}, 32'(rdy_w), 32'd1);
    check({tag, " addr_idle"}, 32'(addr_w), 32'(idx));
    step();
    in_valid = 1'b0;
    check({tag, " busy"}, 32'(busy_w), 32'd1);
    check({tag, " in_ready_busy"}, 32'(rdy_w), 32'd0);
    check({tag, " addr_rda_w"}, 32'(addr_w), 32'(nxt_w));
    check({tag, " addr_rda_c"}, 32'(addr_c), 32'(nxt_c));
    for (int k = 0; k < 3; k++) begin
      check({tag, " early_valid"}, 32'(ov_w), 32'd0);
      step();
    end
    check({tag, " out_valid"}, 32'(ov_w), 32'd1);
    check({tag, " y_wrap"}, y_w, exp_w);
    check({tag, " y_clamp"}, y_c, exp_c);
    step();
    check({tag, " valid_drop"}, 32'(ov_w), 32'd0);
    check({tag, " y_hold"}, y_w, exp_w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 64; k++) ram[k] = 32'(k * 1024);
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_x      = 16'h0000;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    check("rst in_ready", 32'(rdy_w), 32'd1);
    check("rst out_valid", 32'(ov_w), 32'd0);
    check("rst busy", 32'(busy_w), 32'd0);
    check("rst out_y", y_w, 32'd0);
    check("rst clken", 32'(clken_w), 32'd1);
    reset = 1'b0;

    run_txn("exact", 16'h0C00, 32'd3072, 32'd3072);
    run_txn("mid", 16'h0E00, 32'd3584, 32'd3584);
    run_txn("wrap", 16'hFE00, 32'd32256, 32'd64512);

    ram[5] = 32'd0;
    ram[6] = 32'hFFFF_FFFD;
    run_txn("neg_floor", 16'h1401, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    ram[5] = 32'd5120;
    ram[6] = 32'd6144;

    // Backpressure with a second request waiting on in_valid.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = 16'h0A00;
    step();
    in_x = 16'h0C00;
    repeat (3) step();
    for (int k = 0; k < 5; k++) begin
      check("bp out_valid", 32'(ov_w), 32'd1);
      check("bp y_stable", y_w, 32'd2560);
      check("bp in_ready", 32'(rdy_w), 32'd0);
      step();
    end
    check("bp still_out", 32'(ov_w), 32'd1);
    out_ready = 1'b1;
    step();
    check("bp idle_ready", 32'(rdy_w), 32'd1);
    check("bp idle_valid", 32'(ov_w), 32'd0);
    check("bp idle_y", y_w, 32'd2560);
    step();
    in_valid = 1'b0;
    check("bp second_busy", 32'(busy_w), 32'd1);
    repeat (3) step();
    check("bp second_valid", 32'(ov_w), 32'd1);
    check("bp second_y", y_w, 32'd3072);
    step();

    // Reset asserted while the request sits in RD_B.
    in_valid = 1'b1;
    in_x     = 16'h1000;
    step();
    in_valid = 1'b0;
    step();
    check("rst_mid busy", 32'(busy_w), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid out_valid", 32'(ov_w), 32'd0);
    check("rst_mid in_ready", 32'(rdy_w), 32'd1);
    check("rst_mid busy_low", 32'(busy_w), 32'd0);
    check("rst_mid out_y", y_w, 32'd0);
    step();
    check("rst_mid no_result", 32'(ov_w), 32'd0);
    reset = 1'b0;
    step();
    check("rst_mid idle_valid", 32'(ov_w), 32'd0);
    run_txn("after_rst", 16'h0400, 32'd1024, 32'd1024);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
